// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MASK_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        LOCK0 = 2'd3
    } state_t;

    // One requester's view of the shared RAM port.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
        logic              valid;
    } mem_req_t;

    // True while a requester owns the RAM port and a transfer is outstanding.
    function automatic logic is_granted(state_t s);
        return (s == GNT0) || (s == GNT1);
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Transfer watchdog: counts granted cycles without RAM completion.
// Latency: expire_o is combinational from the timer on the last allowed cycle.
// Backpressure: none; clear_i holds the timer at 0, enable_i advances it.
//
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   clear_i     - hold the timer at zero (no transfer in flight)
//   enable_i    - a granted cycle passed without completion
//   expire_o    - this cycle is the last one allowed; the transfer must end
module arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam bit ENABLED = (TIMEOUT_CYCLES > 0);
    localparam int TW      = ENABLED ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] LAST = ENABLED ? TW'(TIMEOUT_CYCLES - 1) : '0;

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // Counting stops at LAST so the timer can never wrap back to a
    // value that would hide a hung transfer.
    always_comb begin
        timer_d = timer_q;
        if (clear_i) begin
            timer_d = '0;
        end else if (enable_i && (timer_q != LAST)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // enable_i already excludes a cycle with ram_ready_i, so a completion
    // landing on the threshold cycle wins over the timeout.
    assign expire_o = ENABLED && enable_i && (timer_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for one valid/ready RAM port, with m0 lock and watchdog.
// Latency: registered grant, ram_valid_o one cycle after request in IDLE; ready passes through combinationally.
// Backpressure: requesters hold valid until their ready pulse; one bubble cycle between transfers.
//
// Ports:
//   clk, reset                          - clock, asynchronous active-high reset
//   m0_* / m1_*                          - requester address/wdata/wmask/valid in, rdata/ready out
//   m0_lock_i                            - requester 0 keeps the port after completion (atomics)
//   ram_addr/wdata/wmask/valid_o         - request to the shared RAM
//   ram_rdata_i, ram_ready_i             - RAM response (ready is a one-cycle pulse)
//   timeout_o                            - one-cycle pulse when a transfer is forcibly terminated
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_wmask_i,
    input  logic        m0_valid_i,
    input  logic        m0_lock_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_ready_o,

    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_wmask_i,
    input  logic        m1_valid_i,
    output logic [31:0] m1_rdata_o,
    output logic        m1_ready_o,

    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    output logic [3:0]  ram_wmask_o,
    output logic        ram_valid_o,
    input  logic [31:0] ram_rdata_i,
    input  logic        ram_ready_i,

    output logic        timeout_o
);

    state_t   state_q;
    state_t   state_d;
    logic     last_grant_q;
    logic     last_grant_d;

    mem_req_t req [NUM_REQ];
    mem_req_t req_sel;

    logic     wd_clear;
    logic     wd_enable;
    logic     wd_expire;

    logic     resp_ready;
    logic [31:0] resp_rdata;

    assign req[0] = '{addr: m0_addr_i, wdata: m0_wdata_i, wmask: m0_wmask_i, valid: m0_valid_i};
    assign req[1] = '{addr: m1_addr_i, wdata: m1_wdata_i, wmask: m1_wmask_i, valid: m1_valid_i};

    assign req_sel = (state_q == GNT1) ? req[1] : req[0];

    // Every entry into GNTx comes from IDLE or LOCK0, so clearing the timer
    // whenever no transfer is outstanding restarts it on each grant.
    assign wd_clear  = !is_granted(state_q);
    assign wd_enable = is_granted(state_q) && !ram_ready_i;

    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (wd_clear),
        .enable_i (wd_enable),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ram_addr_o   = '0;
        ram_wdata_o  = '0;
        ram_wmask_o  = '0;
        ram_valid_o  = 1'b0;
        timeout_o    = 1'b0;
        resp_ready   = 1'b0;
        resp_rdata   = '0;

        case (state_q)
            IDLE: begin
                // On a tie the requester that was not served last wins.
                if (m0_valid_i && m1_valid_i) begin
                    state_d = last_grant_q ? GNT0 : GNT1;
                end else if (m0_valid_i) begin
                    state_d = GNT0;
                end else if (m1_valid_i) begin
                    state_d = GNT1;
                end
            end

            GNT0, GNT1: begin
                ram_addr_o  = req_sel.addr;
                ram_wdata_o = req_sel.wdata;
                ram_wmask_o = req_sel.wmask;
                ram_valid_o = 1'b1;
                resp_ready  = ram_ready_i;
                resp_rdata  = ram_rdata_i;

                if (ram_ready_i) begin
                    last_grant_d = (state_q == GNT1);
                    state_d      = ((state_q == GNT0) && m0_lock_i) ? LOCK0 : IDLE;
                end else if (wd_expire) begin
                    // Abandon the RAM request and complete the requester with
                    // a poison value; any held lock is dropped.
                    ram_valid_o  = 1'b0;
                    timeout_o    = 1'b1;
                    resp_ready   = 1'b1;
                    resp_rdata   = TIMEOUT_DATA;
                    last_grant_d = (state_q == GNT1);
                    state_d      = IDLE;
                end
            end

            LOCK0: begin
                if (m0_valid_i) begin
                    state_d = GNT0;
                end else if (!m0_lock_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response steering: only the owner of the port sees ready/rdata.
    always_comb begin
        m0_ready_o = 1'b0;
        m0_rdata_o = '0;
        m1_ready_o = 1'b0;
        m1_rdata_o = '0;
        if (state_q == GNT0) begin
            m0_ready_o = resp_ready;
            m0_rdata_o = resp_rdata;
        end else if (state_q == GNT1) begin
            m1_ready_o = resp_ready;
            m1_rdata_o = resp_rdata;
        end
    end

    // Reset returns the state to IDLE asynchronously, which forces every
    // output low at once, including ram_valid_o of an in-flight request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 16-cycle watchdog.
// Latency: inputs driven 1 time unit after the rising edge, outputs checked shortly after.
// Backpressure: bench RAM model is scripted per step.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
    logic [3:0]  m0_wmask_i;
    logic        m0_valid_i, m0_lock_i, m0_ready_o;
    logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
    logic [3:0]  m1_wmask_i;
    logic        m1_valid_i, m1_ready_o;
    logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;
    logic [3:0]  ram_wmask_o;
    logic        ram_valid_o, ram_ready_i;
    logic        timeout_o;

    int vectors     = 0;
    int miscompares = 0;
    int n0, n1;
    logic m0_pend, m1_pend;

    mem_arbiter #(
        .TIMEOUT_CYCLES(16),
        .TIMEOUT_DATA  (32'hFFFF_FFFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m0_addr_i   (m0_addr_i),
        .m0_wdata_i  (m0_wdata_i),
        .m0_wmask_i  (m0_wmask_i),
        .m0_valid_i  (m0_valid_i),
        .m0_lock_i   (m0_lock_i),
        .m0_rdata_o  (m0_rdata_o),
        .m0_ready_o  (m0_ready_o),
        .m1_addr_i   (m1_addr_i),
        .m1_wdata_i  (m1_wdata_i),
        .m1_wmask_i  (m1_wmask_i),
        .m1_valid_i  (m1_valid_i),
        .m1_rdata_o  (m1_rdata_o),
        .m1_ready_o  (m1_ready_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_wmask_o (ram_wmask_o),
        .ram_valid_o (ram_valid_o),
        .ram_rdata_i (ram_rdata_i),
        .ram_ready_i (ram_ready_i),
        .timeout_o   (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL sim_budget: simulation did not finish within time limit");
        $fatal(1, "time limit");
    end

    // Requester protocol: valid must stay up from assertion until ready.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_pend <= 1'b0;
            m1_pend <= 1'b0;
        end else begin
            m0_pend <= m0_valid_i && !m0_ready_o;
            m1_pend <= m1_valid_i && !m1_ready_o;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            assert (!(m0_pend && !m0_valid_i)) else begin
                miscompares++;
                $error("FAIL m0_valid_drop: observed valid=0 required valid=1 until ready");
            end
            assert (!(m1_pend && !m1_valid_i)) else begin
                miscompares++;
                $error("FAIL m1_valid_drop: observed valid=0 required valid=1 until ready");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        m0_addr_i   = '0; m0_wdata_i = '0; m0_wmask_i = '0; m0_valid_i = 1'b0; m0_lock_i = 1'b0;
        m1_addr_i   = '0; m1_wdata_i = '0; m1_wmask_i = '0; m1_valid_i = 1'b0;
        ram_rdata_i = '0; ram_ready_i = 1'b0;

        // ---- reset state
        tick();
        chk("rst_ram_valid", 32'(ram_valid_o), 32'd0);
        chk("rst_ram_addr", ram_addr_o, 32'd0);
        chk("rst_flags", 32'({m0_ready_o, m1_ready_o, timeout_o}), 32'd0);
        chk("rst_rdata", m0_rdata_o | m1_rdata_o, 32'd0);
        reset = 1'b0;
        tick();

        // ---- single m0 read, RAM answers in the 3rd granted cycle
        m0_addr_i = 32'h0000_1000; m0_wmask_i = 4'h0; m0_valid_i = 1'b1;
        #1;
        chk("t1_req_cycle_valid", 32'(ram_valid_o), 32'd0);
        tick();
        chk("t1_n1_valid", 32'(ram_valid_o), 32'd1);
        chk("t1_n1_addr", ram_addr_o, 32'h0000_1000);
        chk("t1_n1_m0_ready", 32'(m0_ready_o), 32'd0);
        tick();
        tick();
        ram_ready_i = 1'b1; ram_rdata_i = 32'hDEAD_BEEF;
        #1;
        chk("t1_m0_ready", 32'(m0_ready_o), 32'd1);
        chk("t1_m0_rdata", m0_rdata_o, 32'hDEAD_BEEF);
        chk("t1_m1_ready", 32'(m1_ready_o), 32'd0);
        chk("t1_m1_rdata", m1_rdata_o, 32'd0);
        tick();
        ram_ready_i = 1'b0; m0_valid_i = 1'b0;
        #1;
        chk("t1_bubble", 32'(ram_valid_o), 32'd0);

        // ---- both requesting from reset: strict alternation starting with m0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m0_addr_i = 32'hA000_0000; m0_wmask_i = 4'h0; m0_valid_i = 1'b1;
        m1_addr_i = 32'hB000_0000; m1_wdata_i = 32'h1234_5678; m1_wmask_i = 4'h3; m1_valid_i = 1'b1;
        n0 = 0; n1 = 0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("rr_bubble", 32'(ram_valid_o), 32'd0);
            tick();
            ram_ready_i = 1'b1; ram_rdata_i = 32'(i);
            #1;
            if (i % 2 == 0) begin
                chk("rr_addr_m0", ram_addr_o, 32'hA000_0000);
                chk("rr_wmask_m0", 32'(ram_wmask_o), 32'h0);
                chk("rr_ready_m0", 32'({m0_ready_o, m1_ready_o}), 32'b10);
                chk("rr_rdata_m0", m0_rdata_o, 32'(i));
            end else begin
                chk("rr_addr_m1", ram_addr_o, 32'hB000_0000);
                chk("rr_wdata_m1", ram_wdata_o, 32'h1234_5678);
                chk("rr_wmask_m1", 32'(ram_wmask_o), 32'h3);
                chk("rr_ready_m1", 32'({m0_ready_o, m1_ready_o}), 32'b01);
                chk("rr_rdata_m1", m1_rdata_o, 32'(i));
            end
            if (m0_ready_o) n0++;
            if (m1_ready_o) n1++;
            tick();
            ram_ready_i = 1'b0;
            #1;
        end
        chk("rr_split_m0", 32'(n0), 32'd4);
        chk("rr_split_m1", 32'(n1), 32'd4);
        // m0 still waits; m1 was just served and may drop.
        m1_valid_i = 1'b0;
        tick();
        ram_ready_i = 1'b1;
        #1;
        chk("rr_tail_m0", 32'(m0_ready_o), 32'd1);
        tick();
        ram_ready_i = 1'b0; m0_valid_i = 1'b0;
        #1;

        // ---- m0 atomic read/write with lock while m1 waits
        m0_addr_i = 32'h0000_0080; m0_wmask_i = 4'h0; m0_lock_i = 1'b1; m0_valid_i = 1'b1;
        tick();
        m1_addr_i = 32'h0000_00C0; m1_wmask_i = 4'h0; m1_valid_i = 1'b1;
        ram_ready_i = 1'b1; ram_rdata_i = 32'h0000_0011;
        #1;
        chk("amo_rd_addr", ram_addr_o, 32'h0000_0080);
        chk("amo_rd_ready", 32'({m0_ready_o, m1_ready_o}), 32'b10);
        tick();
        ram_ready_i = 1'b0; m0_valid_i = 1'b0;
        #1;
        chk("amo_lock_valid", 32'(ram_valid_o), 32'd0);
        tick();
        chk("amo_lock_hold", 32'({ram_valid_o, m1_ready_o}), 32'b00);
        m0_wdata_i = 32'hCAFE_F00D; m0_wmask_i = 4'hF; m0_valid_i = 1'b1;
        tick();
        chk("amo_wr_valid", 32'(ram_valid_o), 32'd1);
        chk("amo_wr_data", ram_wdata_o, 32'hCAFE_F00D);
        chk("amo_wr_mask", 32'(ram_wmask_o), 32'hF);
        ram_ready_i = 1'b1;
        #1;
        chk("amo_wr_ready", 32'(m0_ready_o), 32'd1);
        tick();
        ram_ready_i = 1'b0; m0_valid_i = 1'b0; m0_lock_i = 1'b0; m0_wmask_i = 4'h0;
        #1;
        chk("amo_release_lock0", 32'({ram_valid_o, m1_ready_o}), 32'b00);
        tick();
        chk("amo_release_idle", 32'(ram_valid_o), 32'd0);
        tick();
        chk("amo_m1_grant", ram_addr_o, 32'h0000_00C0);
        ram_ready_i = 1'b1;
        #1;
        chk("amo_m1_ready", 32'(m1_ready_o), 32'd1);
        tick();
        ram_ready_i = 1'b0; m1_valid_i = 1'b0;
        #1;

        // ---- watchdog: m1 request, RAM silent
        m1_addr_i = 32'h0000_00D0; m1_valid_i = 1'b1;
        tick();
        for (int k = 1; k < 16; k++) begin
            chk("wd_wait", 32'({m1_ready_o, timeout_o, ram_valid_o}), 32'b001);
            tick();
        end
        chk("wd_m1_ready", 32'(m1_ready_o), 32'd1);
        chk("wd_timeout", 32'(timeout_o), 32'd1);
        chk("wd_rdata", m1_rdata_o, 32'hFFFF_FFFF);
        chk("wd_ram_valid", 32'(ram_valid_o), 32'd0);
        tick();
        m1_valid_i = 1'b0;
        #1;
        chk("wd_after", 32'({timeout_o, ram_valid_o}), 32'b00);
        tick();
        ram_ready_i = 1'b1;
        #1;
        chk("wd_stray_ready", 32'({m0_ready_o, m1_ready_o, timeout_o}), 32'b000);
        tick();
        ram_ready_i = 1'b0;

        // ---- asynchronous reset during a GNT1 wait
        m1_addr_i = 32'h0000_00E0; m1_valid_i = 1'b1;
        tick();
        chk("rst_mid_granted", 32'(ram_valid_o), 32'd1);
        tick();
        reset = 1'b1; ram_ready_i = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(ram_valid_o), 32'd0);
        chk("rst_mid_addr", ram_addr_o, 32'd0);
        chk("rst_mid_flags", 32'({m0_ready_o, m1_ready_o, timeout_o}), 32'b000);
        chk("rst_mid_rdata", m1_rdata_o, 32'd0);
        m1_valid_i = 1'b0; ram_ready_i = 1'b0;
        tick();
        reset = 1'b0;
        m0_addr_i = 32'h0000_2000; m0_valid_i = 1'b1;
        m1_valid_i = 1'b1;
        tick();
        chk("post_rst_m0_first", ram_addr_o, 32'h0000_2000);
        ram_ready_i = 1'b1; ram_rdata_i = 32'h0000_0005;
        #1;
        chk("post_rst_ready", 32'({m0_ready_o, m1_ready_o}), 32'b10);
        tick();
        ram_ready_i = 1'b0; m0_valid_i = 1'b0;
        tick();
        chk("post_rst_m1_next", ram_addr_o, 32'h0000_00E0);
        ram_ready_i = 1'b1;
        #1;
        tick();
        ram_ready_i = 1'b0; m1_valid_i = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
